// File: rtl/rd_sched.sv
// rd_sched: round-robin read scheduler for NQ FIFO read ports.
// Each grant selects one non-empty FIFO (searching upward from the last
// served index) and pops it while downstream is ready, until the burst
// completes or the FIFO drains.
//
// Build option: define RD_SCHED_BURST_EN to allow up to BURST pops per
// grant. Without it every grant is a single pop (per-word round-robin)
// and the burst counter is not built.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no grant; search for the next non-empty FIFO (one bubble)
// S_SERVE | FIFO sel granted; pop while out_ready and not empty

module rd_sched #(
    parameter int NQ    = 4,
    parameter int BURST = 4
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [NQ-1:0]         rempty,
    input  logic                  out_ready,
    output logic [NQ-1:0]         rinc,
    output logic [$clog2(NQ)-1:0] sel,
    output logic                  out_valid,
    output logic                  busy
);

    localparam int SW = $clog2(NQ);

`ifdef RD_SCHED_BURST_EN
    localparam int EB = BURST;
`else
    // Per-word mode: BURST is accepted but every grant is exactly one pop.
    localparam int EB = (BURST > 0) ? 1 : 1;
`endif

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SERVE = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_sel;
    logic [SW-1:0] r_last;
    logic [SW-1:0] w_cand;
    logic [SW-1:0] w_next_idx;
    logic          w_found;
    logic          w_pop;
    logic          w_burst_done;
    logic [NQ-1:0] w_rinc;

    // Round-robin search: first non-empty index from last+1 upward.
    // NQ is a power of two, so the SW-bit add wraps modulo NQ for free.
    always_comb begin
        w_found    = 1'b0;
        w_next_idx = '0;
        w_cand     = '0;
        for (int k = 1; k <= NQ; k++) begin
            w_cand = r_last + SW'(k);
            if (!w_found && !rempty[w_cand]) begin
                w_found    = 1'b1;
                w_next_idx = w_cand;
            end
        end
    end

    // Next-state and pop decode; pops follow the current-cycle empty flag,
    // so a late or just-risen rempty can never cause a pop of an empty FIFO.
    always_comb begin
        w_state_nxt = r_state;
        w_rinc      = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_SERVE;
                end
            end
            S_SERVE: begin
                if (!rempty[r_sel] && out_ready) begin
                    w_rinc[r_sel] = 1'b1;
                end
                // A drained queue ends the grant ahead of burst completion.
                if (rempty[r_sel]) begin
                    w_state_nxt = S_IDLE;
                end else if (out_ready && w_burst_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_pop     = |w_rinc;
    assign rinc      = w_rinc;
    assign out_valid = w_pop;
    assign sel       = r_sel;
    assign busy      = (r_state == S_SERVE);

    // State, grant index and last-served index.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_last  <= SW'(NQ - 1);
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_found) begin
                r_sel <= w_next_idx;
            end
            if (r_state == S_SERVE && w_state_nxt == S_IDLE) begin
                r_last <= r_sel;
            end
        end
    end

`ifdef RD_SCHED_BURST_EN
    logic [7:0] r_cnt;

    assign w_burst_done = (r_cnt == 8'(EB - 1));

    // Pops in the current grant; cleared on grant, saturating at BURST.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE && w_found) begin
            r_cnt <= '0;
        end else if (w_pop && r_cnt != 8'(EB)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    // Every pop completes the grant.
    assign w_burst_done = (EB == 1);
`endif

endmodule

// File: tb/tb_rd_sched.sv
// tb_rd_sched: scoreboard bench for rd_sched (NQ=4, BURST=4).
// Expected pop order is pushed when FIFO contents are loaded and popped
// as the DUT issues rinc. Follows RD_SCHED_BURST_EN for the grant size.

module tb_rd_sched;

    localparam int NQ    = 4;
    localparam int BURST = 4;
`ifdef RD_SCHED_BURST_EN
    localparam int EB = BURST;
`else
    localparam int EB = 1;
`endif

    logic          rclk      = 1'b0;
    logic          rrst      = 1'b1;
    logic          out_ready = 1'b0;
    logic [NQ-1:0] rempty;
    logic [NQ-1:0] rinc;
    logic [1:0]    sel;
    logic          out_valid;
    logic          busy;

    int fifo_cnt [NQ] = '{default: 0};
    int exp_q [$];
    int pop_cyc [$];
    int cyc    = 0;
    int grants = 0;
    int n_chk  = 0;
    int n_pass = 0;

    always #5 rclk = ~rclk;

    always_comb begin
        rempty = '0;
        for (int i = 0; i < NQ; i++) rempty[i] = (fifo_cnt[i] == 0);
    end

    rd_sched #(.NQ(NQ), .BURST(BURST)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rempty    (rempty),
        .out_ready (out_ready),
        .rinc      (rinc),
        .sel       (sel),
        .out_valid (out_valid),
        .busy      (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    // Reference round-robin order for FIFO loads w[], search starting at start.
    task automatic push_rr(input int w [NQ], input int start, output int last);
        int rem [NQ];
        int total;
        int pick;
        int n;
        int st;
        total = 0;
        st    = start;
        last  = -1;
        for (int i = 0; i < NQ; i++) begin
            rem[i] = w[i];
            total += w[i];
        end
        while (total > 0) begin
            pick = -1;
            for (int s = 0; s < NQ; s++)
                if (pick < 0 && rem[(st + s) % NQ] > 0) pick = (st + s) % NQ;
            n = (rem[pick] < EB) ? rem[pick] : EB;
            for (int j = 0; j < n; j++) exp_q.push_back(pick);
            rem[pick] -= n;
            total     -= n;
            st   = (pick + 1) % NQ;
            last = pick;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int i;
        i = 0;
        while (i < budget && (exp_q.size() != 0 || busy)) begin
            tick();
            i++;
        end
        repeat (3) tick();
        chk({tag, "_done"}, exp_q.size(), 0);
        chk({tag, "_idle"}, int'(busy), 0);
    endtask

    // Full grants give gaps of 1 inside a burst and 2 across the bubble.
    task automatic chk_gaps(input string tag);
        for (int k = 1; k < pop_cyc.size(); k++)
            chk(tag, pop_cyc[k] - pop_cyc[k-1], (k % EB == 0) ? 2 : 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rinc"}, int'(rinc), 0);
        chk({tag, "_ov"}, int'(out_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_sel"}, int'(sel), 0);
    endtask

    // Monitor: check each pop at the falling edge, apply it to the FIFO model
    // just after the rising edge that performs it.
    initial begin
        logic [NQ-1:0] pend;
        logic          busy_q;
        busy_q = 1'b0;
        forever begin
            @(negedge rclk);
            cyc++;
            chk("ov_or", int'(out_valid), int'(|rinc));
            if (out_valid) begin
                chk("rinc_onehot", int'(rinc), 1 << sel);
                chk("pop_ready", int'(out_ready), 1);
                chk("pop_nonempty", int'(fifo_cnt[sel] > 0), 1);
                if (exp_q.size() == 0) chk("sb_pending", exp_q.size(), 1);
                else chk("pop_sel", int'(sel), exp_q.pop_front());
                pop_cyc.push_back(cyc);
            end
            if (busy && !busy_q) grants++;
            busy_q = busy;
            pend   = rinc;
            @(posedge rclk);
            #1;
            for (int i = 0; i < NQ; i++)
                if (pend[i] && fifo_cnt[i] > 0) fifo_cnt[i]--;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d expected pops pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int wl [NQ];
        int g0;
        int lst;
        int i;

        // Reset with empty FIFOs.
        rrst      = 1'b1;
        out_ready = 1'b0;
        repeat (3) begin
            tick();
            chk_reset("rst0");
        end
        rrst = 1'b0;
        tick();

        // Burst: FIFO1 holds 10 words -> 4,bubble,4,bubble,2.
        pop_cyc.delete();
        g0 = grants;
        wl = '{0, 10, 0, 0};
        push_rr(wl, 0, lst);
        out_ready   = 1'b1;
        fifo_cnt[1] = 10;
        wait_idle("burst", 100);
        chk("burst_pops", pop_cyc.size(), 10);
        chk_gaps("burst_gap");
        chk("burst_grants", grants - g0, (10 + EB - 1) / EB);

        // Reset mid-burst on FIFO2 (searched from last+1 = 2).
        out_ready   = 1'b0;
        fifo_cnt[2] = 8;
        for (int j = 0; j < ((EB >= 2) ? 2 : 1); j++) exp_q.push_back(2);
        i = 0;
        while (!busy && i < 20) begin
            tick();
            i++;
        end
        chk("mid_grant", int'(busy), 1);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        rrst      = 1'b1;
        tick();
        chk("mid_pops", exp_q.size(), 0);
        for (int q = 0; q < NQ; q++) fifo_cnt[q] = 8;
        out_ready = 1'b1;
        repeat (3) begin
            chk_reset("rst1");
            tick();
        end

        // Fairness after release: all FIFOs hold 8, search starts at 0.
        pop_cyc.delete();
        g0 = grants;
        wl = '{8, 8, 8, 8};
        push_rr(wl, 0, lst);
        rrst = 1'b0;
        wait_idle("fair", 300);
        chk("fair_pops", pop_cyc.size(), 32);
        chk_gaps("fair_gap");
        chk("fair_grants", grants - g0, 32 / EB);

        // Drain: FIFO2 holds 2 words; last becomes 2, sel holds in IDLE.
        pop_cyc.delete();
        g0 = grants;
        wl = '{0, 0, 2, 0};
        push_rr(wl, 0, lst);
        fifo_cnt[2] = 2;
        wait_idle("drain", 50);
        chk("drain_pops", pop_cyc.size(), 2);
        chk_gaps("drain_gap");
        chk("drain_grants", grants - g0, (2 + EB - 1) / EB);
        chk("idle_sel_hold", int'(sel), 2);

        // last==2: FIFO3 must win over FIFO1 when both appear together.
        wl = '{0, 1, 0, 1};
        push_rr(wl, 3, lst);
        fifo_cnt[1] = 1;
        fifo_cnt[3] = 1;
        wait_idle("rr_last", 50);
        chk("rr_last_sel", int'(sel), 1);

        // Back-pressure on FIFO0 (search wraps from 2 to 0).
        pop_cyc.delete();
        g0 = grants;
        wl = '{4, 0, 0, 0};
        push_rr(wl, 2, lst);
        out_ready   = 1'b0;
        fifo_cnt[0] = 4;
        i = 0;
        while (i < 80 && (exp_q.size() != 0 || busy)) begin
            out_ready = ~out_ready;
            tick();
            i++;
        end
        out_ready = 1'b1;
        wait_idle("bp", 20);
        chk("bp_pops", pop_cyc.size(), 4);
        chk("bp_grants", grants - g0, (4 + EB - 1) / EB);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rd_sched.md
RD_SCHED -- requirements
Module: rd_sched

Interface
REQ-001 The module SHALL have parameter NQ, default 4, giving the number of FIFO read ports scheduled; legal values are 2, 4 and 8.
REQ-002 The module SHALL have parameter BURST, default 4, giving the maximum consecutive pops per grant; legal range is 1..255.
REQ-003 The module SHALL have port rclk, input, 1 bit: the single clock, rising edge.
REQ-004 The module SHALL have port rrst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The module SHALL have port rempty, input, NQ bits: per-FIFO empty flags, 1 = empty.
REQ-006 The module SHALL have port out_ready, input, 1 bit: downstream can accept one word this cycle.
REQ-007 The module SHALL have port rinc, output, NQ bits: per-FIFO read increment, at most one bit set.
REQ-008 The module SHALL have port sel, output, log2(NQ) bits: index of the granted FIFO, drives the read-data mux.
REQ-009 The module SHALL have port out_valid, output, 1 bit: equals OR of rinc, so the word from FIFO sel is transferred this cycle.
REQ-010 The module SHALL have port busy, output, 1 bit: 1 while in SERVE.

Function
REQ-011 The module SHALL implement two states: IDLE and SERVE.
REQ-012 In IDLE, when any rempty bit is 0, the module SHALL go to SERVE at the next edge, load sel with the first non-empty index searched from last+1 upward, modulo NQ, and clear cnt.
REQ-013 In IDLE, rinc SHALL be all zeros, and sel SHALL hold its previous value.
REQ-014 In SERVE, rinc[sel] SHALL be combinationally 1 iff rempty[sel]==0 and out_ready==1; all other rinc bits SHALL be 0.
REQ-015 Each cycle with out_valid==1 SHALL increment cnt, which is 8 bits wide and saturates at BURST.
REQ-016 SERVE SHALL exit to IDLE at the edge where out_valid==1 and cnt==BURST-1 (burst complete).
REQ-017 SERVE SHALL also exit to IDLE at any edge where rempty[sel]==1 (queue drained); this takes priority over REQ-016.
REQ-018 On every exit from SERVE, last SHALL be loaded with sel.
REQ-019 With out_ready==0 in SERVE, the module SHALL hold its state, cnt and sel, and SHALL issue no rinc; there is no timeout.
REQ-020 Each grant SHALL cost one bubble cycle in IDLE, so peak throughput is BURST/(BURST+1) words per cycle.
REQ-021 Wrap-around: with last==NQ-1, the search SHALL start at index 0.
REQ-022 The search SHALL be combinational over all NQ candidates, so that no non-empty FIFO waits more than NQ-1 grants (round-robin fairness).
REQ-023 Simultaneous rempty[sel] rising and out_ready: rinc SHALL follow the current-cycle rempty, and no pop SHALL be issued to an empty FIFO.
REQ-024 rempty flags that are asserted late (pessimistic synchronised empty) SHALL only delay grants and SHALL never cause a pop to an empty FIFO.

Reset
REQ-025 When rrst==1 at a rising rclk edge, the module SHALL enter IDLE, with sel=0, last=NQ-1, cnt=0 and busy=0.
REQ-026 rinc and out_valid SHALL be 0 in the cycle after reset is sampled and while rrst is held.
REQ-027 Reset asserted mid-burst SHALL abandon the burst with no further rinc; the first grant after release SHALL search from index 0.

Configuration
REQ-028 Macro RD_SCHED_BURST_EN defined: the module SHALL use burst grants of up to BURST pops as specified above.
REQ-029 Macro RD_SCHED_BURST_EN undefined: the module SHALL treat BURST as 1, so SERVE exits after every pop (pure per-word round-robin), and the cnt register SHALL be removed.

Verification
REQ-030 Reset: hold rrst high 3 cycles with all FIFOs non-empty -> rinc=0, busy=0, sel=0; the first grant after release goes to FIFO 0.
REQ-031 Burst: NQ=4, BURST=4, FIFO1 holds 10 words, others empty, out_ready=1 -> pop pattern 4 pops, bubble, 4 pops, bubble, 2 pops, IDLE; out_valid count is 10.
REQ-032 Fairness: all four FIFOs hold 8 words, BURST=4 -> sel sequence 0,1,2,3,0,1,2,3; each sel value sees 4 consecutive pops.
REQ-033 Drain: FIFO2 holds 2 words, BURST=4 -> 2 pops, rempty[2] rises, exit to IDLE, last=2, no third rinc.
REQ-034 Back-pressure: toggle out_ready 0/1 every cycle during a burst on FIFO0 -> rinc only in cycles where out_ready==1, cnt frozen otherwise, 4 pops total per grant.
REQ-035 Macro off: all FIFOs non-empty -> sel rotates 0,1,2,3 with exactly 1 pop per grant and a pop every second cycle.
